uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped serial transmitter on the CPU data bus, alongside the RAM. It decodes a two-word address window and buffers 16-bit store words in a small FIFO. Each word is sent on a UART TX line as two 8-bit frames, low byte first. The top level routes `WE`, `dataAddress` and `writeData` from the datapath to both RAM and this block, and muxes `ioReadData` into `readData` when `ioSel` is high.

## Interface
Parameters:
- `ADDR_W`, 10, data address width (matches the datapath).
- `DATA_W`, 16, data word width.
- `BASE_ADDR`, 10'h3F0, window base. `BASE+0` = TXDATA, `BASE+1` = STATUS.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, 8, word entries, power of two.

Ports:
- `clk`, in, 1, sole clock, rising edge.
- `reset`, in, 1, asynchronous, active-low; clears all state immediately.
- `WE`, in, 1, store strobe from the datapath, sampled at the rising edge.
- `dataAddress`, in, ADDR_W, data bus address.
- `writeData`, in, DATA_W, store data.
- `ioSel`, out, 1, combinational; high when `dataAddress` is `BASE` or `BASE+1`.
- `ioReadData`, out, DATA_W, combinational read data.
- `tx`, out, 1, serial line, idle high.
- `txBusy`, out, 1, high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- **Push:** `WE` high with `dataAddress == BASE` pushes `writeData` into the FIFO.
  - If the FIFO is full, the word is dropped and sticky `ovf` is set.
  - Exception: a push to a full FIFO in the same cycle as a pop is accepted.
- **Clear overflow:** `WE` high with `dataAddress == BASE+1` clears `ovf`. The data value is ignored.
- **Reads:**
  - STATUS = {`count`[bits 7:4], `ovf`[3], `txBusy`[2], `empty`[1], `full`[0]}, upper bits 0.
  - TXDATA reads and out-of-window addresses return 0.
  - `count` saturates at 15 for display.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: if the FIFO is non-empty, pop a word into a 16-bit shift register, set `hiByte`=0, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each, bit index 0..7.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
    - if `hiByte`=0: set `hiByte`=1 and go directly to START (no gap);
    - otherwise go to IDLE.
- **Counters:** baud counter is `$clog2(CLKS_PER_BIT)` bits, counting 0..CLKS_PER_BIT-1; the bit advances on terminal count. Bit index is 3 bits and wraps to 0 on DATA exit.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)`+1 bits; the MSB distinguishes full from empty.

## Timing
- **Reset values:** `tx`=1, `txBusy`=0, FIFO empty, `ovf`=0, FSM IDLE, counters 0. `ioSel`/`ioReadData` follow the inputs combinationally.
- **Push visibility:** a push at edge N is visible in STATUS after edge N.
- **Start latency:** if idle, the pop occurs at edge N+1 and `tx` falls after edge N+1 (one-cycle start latency).
- **Word length:** one word = 20·CLKS_PER_BIT cycles (22·CLKS_PER_BIT with parity).
- **Inter-word gap:** exactly one IDLE cycle with `tx`=1 between consecutive words.
- **Reset mid-frame:** `tx` goes high asynchronously; the partial frame is abandoned; FIFO contents are lost.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP;
  - drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles;
  - frame is 11 bits.
- Undefined: no PARITY state, 10-bit frame. Register map is identical in both builds.

## Structure
- **Package `uart_mmio_pkg`:** FSM state enum, register offsets (`TXDATA_OFS`=0, `STATUS_OFS`=1), STATUS bit positions.
- **Sub-module `sync_fifo`:** parameterised width/depth; push, pop, full, empty and count outputs.
- Decode, FSM and shifter live in `uart_tx_mmio`.

## Test plan
- **Single word:** CLKS_PER_BIT=4, write 16'hA55A to 10'h3F0. Expect `tx` low 4 cycles after the next edge, then 0x5A bits 0,1,0,1,1,0,1,0 (4 cycles each), stop, immediate start, then 0xA5. Total 80 cycles; `txBusy` drops afterwards.
- **Overflow:** write 9 words back-to-back while the FSM holds the first. Expect STATUS `full`=1, `ovf`=1, 9th word never transmitted. Writing STATUS clears `ovf`; other bits are unchanged.
- **Push-on-full with pop:** fill the FIFO and push in exactly the cycle IDLE pops. Expect the word accepted, `ovf` stays 0, `count` stays 8.
- **Decode:** read 10'h3F1 on empty idle: `ioSel`=1, `ioReadData`=16'h0002. Read 10'h3EF: `ioSel`=0, 0. Store to 10'h3EF: no push.
- **Reset mid-DATA:** assert `reset` low during bit 3. Expect `tx`=1 the same cycle, STATUS 16'h0002 after release, no residual frame.
- **Parity build (`UART_TX_PARITY_EN`):** write 16'h0007. Expect parity bit 1 after byte 0x07 and 0 after 0x00. Word spans 88 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_pkg
// Description : Shared types and constants for the memory-mapped UART
//               transmitter: FSM state encoding, register offsets inside the
//               two-word window, and STATUS register bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_mmio_pkg;

    // Transmitter states; PARITY is only entered when parity is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } txState_t;

    // Word offsets from the window base
    localparam int unsigned TXDATA_OFS = 0;
    localparam int unsigned STATUS_OFS = 1;

    // STATUS register layout (upper bits read as zero)
    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_BUSY_BIT  = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;
    localparam int unsigned STAT_CNT_LSB   = 4;
    localparam int unsigned STAT_CNT_W     = 4;

    // Clamp the FIFO occupancy to the 4-bit display field
    function automatic logic [3:0] satCount(input logic [31:0] cnt);
        if (cnt > 32'd15) begin
            return 4'hF;
        end
        return cnt[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO. Pointers carry one extra wrap bit so that
//               full and empty are distinguished without a separate counter.
//               A push while full is accepted when a pop happens in the same
//               cycle, since the pop frees the slot being written.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wrData,
    output logic [WIDTH-1:0]         o_rdData,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wrPtr;
    logic [PTR_W:0]   r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                      (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign o_count  = r_wrPtr - r_rdPtr;
    assign o_rdData = r_mem[r_rdPtr[PTR_W-1:0]];

    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    // Pointer update; clearing the pointers discards any stored words
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[PTR_W-1:0]] <= i_wrData;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped UART transmitter. BASE+0 (TXDATA) accepts 16-bit
//               words into a FIFO, BASE+1 (STATUS) reports FIFO/FSM state and
//               clears the sticky overflow flag on write. Each word is sent as
//               two 8N1 frames, low byte first, back to back.
//               Optional macro UART_TX_PARITY_EN adds an even-parity bit
//               after the data bits of every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter int                ADDR_W       = 10,
    parameter int                DATA_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 10'h3F0,
    parameter int                CLKS_PER_BIT = 16,
    parameter int                FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] dataAddress,
    input  logic [DATA_W-1:0] writeData,
    output logic              ioSel,
    output logic [DATA_W-1:0] ioReadData,
    output logic              tx,
    output logic              txBusy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] c_txdataAddr = BASE_ADDR + ADDR_W'(TXDATA_OFS);
    localparam logic [ADDR_W-1:0] c_statusAddr = BASE_ADDR + ADDR_W'(STATUS_OFS);
    localparam logic [BAUD_W-1:0] c_lastTick   = BAUD_W'(CLKS_PER_BIT - 1);

    // FSM and shifter state
    txState_t          r_state;
    txState_t          w_stateNext;
    logic [BAUD_W-1:0] r_baudCnt;
    logic [BAUD_W-1:0] w_baudNext;
    logic [2:0]        r_bitIdx;
    logic [2:0]        w_bitIdxNext;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shiftNext;
    logic              r_hiByte;
    logic              w_hiByteNext;
    logic              r_tx;
    logic              w_txNext;
    logic              w_baudTick;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
    logic              w_parityNext;
`endif

    // Bus decode and FIFO interface
    logic              w_push;
    logic              w_ovfClr;
    logic              w_pop;
    logic              r_ovf;
    logic [DATA_W-1:0] w_fifoDout;
    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic [CNT_W-1:0]  w_fifoCount;
    logic [7:0]        w_status;

    assign w_push   = WE && (dataAddress == c_txdataAddr);
    assign w_ovfClr = WE && (dataAddress == c_statusAddr);
    assign ioSel    = (dataAddress == c_txdataAddr) || (dataAddress == c_statusAddr);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wrData (writeData),
        .o_rdData (w_fifoDout),
        .o_full   (w_fifoFull),
        .o_empty  (w_fifoEmpty),
        .o_count  (w_fifoCount)
    );

    assign w_baudTick = (r_baudCnt == c_lastTick);
    assign txBusy     = (r_state != ST_IDLE) || !w_fifoEmpty;
    assign tx         = r_tx;

    // Sticky overflow: set when a push is dropped, cleared by a STATUS write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_fifoFull && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_ovfClr) begin
            r_ovf <= 1'b0;
        end
    end

    // STATUS assembly and read-data mux; TXDATA and other addresses read 0
    always_comb begin
        w_status                              = '0;
        w_status[STAT_FULL_BIT]               = w_fifoFull;
        w_status[STAT_EMPTY_BIT]              = w_fifoEmpty;
        w_status[STAT_BUSY_BIT]               = txBusy;
        w_status[STAT_OVF_BIT]                = r_ovf;
        w_status[STAT_CNT_LSB +: STAT_CNT_W]  = satCount(32'(w_fifoCount));
        ioReadData = '0;
        if (dataAddress == c_statusAddr) begin
            ioReadData[7:0] = w_status;
        end
    end

    // FSM state, counters, shifter and a registered serial output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_hiByte  <= 1'b0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_stateNext;
            r_baudCnt <= w_baudNext;
            r_bitIdx  <= w_bitIdxNext;
            r_shift   <= w_shiftNext;
            r_hiByte  <= w_hiByteNext;
            r_tx      <= w_txNext;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parityNext;
`endif
        end
    end

    // Next-state logic; tx is derived from the next state so it changes
    // exactly on the edge that enters each bit
    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = '0;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_hiByteNext = r_hiByte;
        w_pop        = 1'b0;
        w_txNext     = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parityNext = r_parity;
`endif
        if (r_state != ST_IDLE) begin
            w_baudNext = w_baudTick ? '0 : r_baudCnt + BAUD_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop        = 1'b1;
                    w_shiftNext  = w_fifoDout;
                    w_hiByteNext = 1'b0;
                    w_stateNext  = ST_START;
                end
            end
            ST_START: begin
                if (w_baudTick) begin
                    w_stateNext  = ST_DATA;
`ifdef UART_TX_PARITY_EN
                    w_parityNext = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (w_baudTick) begin
                    w_shiftNext = r_shift >> 1;
`ifdef UART_TX_PARITY_EN
                    w_parityNext = r_parity ^ r_shift[0];
`endif
                    if (r_bitIdx == 3'd7) begin
                        w_bitIdxNext = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_stateNext  = ST_PARITY;
`else
                        w_stateNext  = ST_STOP;
`endif
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baudTick) begin
                    w_stateNext = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_baudTick) begin
                    if (!r_hiByte) begin
                        // High byte follows immediately with no idle gap
                        w_hiByteNext = 1'b1;
                        w_stateNext  = ST_START;
                    end else begin
                        w_stateNext  = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase

        case (w_stateNext)
            ST_START:  w_txNext = 1'b0;
            ST_DATA:   w_txNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txNext = w_parityNext;
`endif
            default:   w_txNext = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Directed self-checking bench for uart_tx_mmio at
//               CLKS_PER_BIT=4. A line monitor decodes complete words into a
//               queue; directed steps check STATUS, decode, exact bit timing,
//               overflow, push-on-full with pop and reset mid-frame.
//               Honours UART_TX_PARITY_EN for frame length and parity bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYC = 2 * FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        WE = 1'b0;
    logic [9:0]  dataAddress = 10'h3F1;
    logic [15:0] writeData = '0;
    logic        ioSel;
    logic [15:0] ioReadData;
    logic        tx;
    logic        txBusy;

    int          total = 0;
    int          bad = 0;
    logic [15:0] rxQ [$];

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .ADDR_W       (10),
        .DATA_W       (16),
        .BASE_ADDR    (10'h3F0),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .WE          (WE),
        .dataAddress (dataAddress),
        .writeData   (writeData),
        .ioSel       (ioSel),
        .ioReadData  (ioReadData),
        .tx          (tx),
        .txBusy      (txBusy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        WE = 1'b0;
        dataAddress = 10'h3F1;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        rxQ.delete();
    endtask

    task automatic writeWord(input logic [9:0] a, input logic [15:0] d);
        WE = 1'b1;
        dataAddress = a;
        writeData = d;
        tick();
        WE = 1'b0;
        dataAddress = 10'h3F1;
    endtask

    task automatic checkStatus(input string tag, input logic [15:0] exp);
        dataAddress = 10'h3F1;
        #1;
        check(tag, ioReadData, exp);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (txBusy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, txBusy, 0);
    endtask

    // Cycle-exact line check of one word; call right after its push edge
    task automatic checkWordExact(input string tag, input logic [15:0] d);
        logic [2*11-1:0] exp;
        logic [7:0]      by;
        int              n;
        exp = '0;
        n = 0;
        for (int f = 0; f < 2; f++) begin
            by = d[f*8 +: 8];
            exp[n] = 1'b0;
            n++;
            for (int i = 0; i < 8; i++) begin
                exp[n] = by[i];
                n++;
            end
            if (FRAME_BITS == 11) begin
                exp[n] = ^by;
                n++;
            end
            exp[n] = 1'b1;
            n++;
        end
        check({tag, "_latency"}, tx, 1);
        tick();
        for (int k = 0; k < WORD_CYC; k++) begin
            check($sformatf("%s_c%0d", tag, k), tx, exp[k / CPB]);
            if (k == WORD_CYC / 2) begin
                check({tag, "_midstat"}, ioReadData, 16'h0006);
            end
            tick();
        end
        check({tag, "_busy_end"}, txBusy, 0);
        check({tag, "_tx_end"}, tx, 1);
    endtask

    // Line monitor: decodes whole words, abandons any frame cut by reset
    initial begin : monitor
        logic [15:0] w;
        bit          aborted;
        int          bp;
        int          fr;
        int          bi;
        forever begin
            tick();
            if (reset === 1'b1 && tx === 1'b0) begin
                w = '0;
                aborted = 1'b0;
                for (int c = 1; c < WORD_CYC; c++) begin
                    tick();
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % CPB == CPB / 2) begin
                        bp = c / CPB;
                        fr = bp / FRAME_BITS;
                        bi = bp % FRAME_BITS;
                        if (bi >= 1 && bi <= 8) begin
                            w[fr*8 + bi - 1] = tx;
                        end
                    end
                end
                if (!aborted) begin
                    rxQ.push_back(w);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lowCnt;

        // Reset state while reset is held
        reset = 1'b0;
        repeat (2) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", txBusy, 0);
        checkStatus("rst_status", 16'h0002);
        reset = 1'b1;
        tick();

        // Decode
        dataAddress = 10'h3F1; #1;
        check("dec_sel_status", ioSel, 1);
        check("dec_rd_status", ioReadData, 16'h0002);
        dataAddress = 10'h3EF; #1;
        check("dec_sel_below", ioSel, 0);
        check("dec_rd_below", ioReadData, 16'h0000);
        dataAddress = 10'h3F0; #1;
        check("dec_sel_txdata", ioSel, 1);
        check("dec_rd_txdata", ioReadData, 16'h0000);
        dataAddress = 10'h3F2; #1;
        check("dec_sel_above", ioSel, 0);
        writeWord(10'h3EF, 16'h1234);
        checkStatus("dec_nopush_status", 16'h0002);
        tick();
        check("dec_nopush_tx", tx, 1);
        check("dec_nopush_busy", txBusy, 0);

        // Single word, cycle exact
        doReset();
        writeWord(10'h3F0, 16'hA55A);
        checkStatus("single_push_status", 16'h0014);
        checkWordExact("single", 16'hA55A);
        check("single_rx_n", rxQ.size(), 1);
        check("single_rx_w", (rxQ.size() > 0) ? rxQ[0] : 16'hxxxx, 16'hA55A);

        // Overflow: first word in the FSM, then nine more; the ninth is dropped
        doReset();
        writeWord(10'h3F0, 16'hC300);
        tick();
        for (int k = 1; k <= 9; k++) begin
            writeWord(10'h3F0, 16'hC300 + 16'(k));
        end
        checkStatus("ovf_status", 16'h008D);
        writeWord(10'h3F1, 16'hFFFF);
        checkStatus("ovf_cleared", 16'h0085);
        waitIdle("ovf", 12 * WORD_CYC);
        check("ovf_rx_n", rxQ.size(), 9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("ovf_rx%0d", k), (k < rxQ.size()) ? rxQ[k] : 16'hxxxx,
                  16'hC300 + 16'(k));
        end
        checkStatus("ovf_final", 16'h0002);

        // Push to a full FIFO in the exact cycle the FSM pops
        doReset();
        writeWord(10'h3F0, 16'h5A00);
        tick();
        for (int k = 1; k <= 8; k++) begin
            writeWord(10'h3F0, 16'h5A00 + 16'(k));
        end
        checkStatus("pof_full", 16'h0085);
        repeat (WORD_CYC + 1 - 9) tick();
        check("pof_gap_tx", tx, 1);
        writeWord(10'h3F0, 16'h5A09);
        checkStatus("pof_after", 16'h0085);
        waitIdle("pof", 14 * WORD_CYC);
        check("pof_rx_n", rxQ.size(), 10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("pof_rx%0d", k), (k < rxQ.size()) ? rxQ[k] : 16'hxxxx,
                  16'h5A00 + 16'(k));
        end

        // Reset during data bit 3 of a zero byte
        doReset();
        writeWord(10'h3F0, 16'h0000);
        repeat (18) tick();
        check("rmid_tx_low", tx, 0);
        #3;
        reset = 1'b0;
        #1;
        check("rmid_tx_async", tx, 1);
        check("rmid_busy_async", txBusy, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        checkStatus("rmid_status", 16'h0002);
        lowCnt = 0;
        repeat (2 * WORD_CYC) begin
            tick();
            if (tx !== 1'b1) lowCnt++;
        end
        check("rmid_line_idle", lowCnt, 0);
        check("rmid_rx_n", rxQ.size(), 0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 gives 1, 0x00 gives 0
        doReset();
        writeWord(10'h3F0, 16'h0007);
        checkWordExact("par", 16'h0007);
        check("par_rx_w", (rxQ.size() > 0) ? rxQ[0] : 16'hxxxx, 16'h0007);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
